// File: rtl/count_display_driver.sv
// Converts the 12-bit counter value to BCD with a serial double-dabble engine
// and scans the latched result onto a 4-digit common-anode 7-segment display.
module count_display_driver #(
   parameter logic [15:0] SCAN_DIV = 16'd50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] count,
   output logic [15:0] bcd,
   output logic        bcd_valid,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   typedef enum logic [1:0] {IDLE, CONVERT, LATCH} state_t;

   state_t      state_reg, state_next;
   logic [27:0] dabble_reg, dabble_next;
   logic [3:0]  iter_reg, iter_next;
   logic [15:0] bcd_reg, bcd_next;
   logic        valid_reg, valid_next;
   logic [27:0] dabble_adj;

   // Add-3 correction on each BCD nibble before the shift; binary part passes through.
   assign dabble_adj[11:0] = dabble_reg[11:0];
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_adj
         assign dabble_adj[12 + 4*gi +: 4] = (dabble_reg[12 + 4*gi +: 4] >= 4'd5)
                                            ? dabble_reg[12 + 4*gi +: 4] + 4'd3
                                            : dabble_reg[12 + 4*gi +: 4];
      end
   endgenerate

   always_comb begin
      state_next  = state_reg;
      dabble_next = dabble_reg;
      iter_next   = iter_reg;
      bcd_next    = bcd_reg;
      valid_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            dabble_next = {16'h0000, count};
            iter_next   = 4'd0;
            state_next  = CONVERT;
         end
         CONVERT: begin
            dabble_next = dabble_adj << 1;
            iter_next   = iter_reg + 4'd1;
            if (iter_reg == 4'd11)
               state_next = LATCH;
         end
         LATCH: begin
            bcd_next   = dabble_reg[27:12];
            valid_next = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         dabble_reg <= 28'h0;
         iter_reg   <= 4'd0;
         bcd_reg    <= 16'h0000;
         valid_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         dabble_reg <= dabble_next;
         iter_reg   <= iter_next;
         bcd_reg    <= bcd_next;
         valid_reg  <= valid_next;
      end
   end

   // Display scanner
   logic [15:0] pre_reg, pre_next;
   logic [1:0]  idx_reg, idx_next;
   logic [3:0]  an_reg, an_next;
   logic [6:0]  seg_reg, seg_next;
   logic [3:0]  digit [4];
   logic [3:0]  blank;
   logic        wrap;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_digit
         assign digit[gi] = bcd_reg[4*gi +: 4];
      end
      // A digit is blank when it and every higher digit are zero; ones never blanks.
      for (genvar gi = 1; gi < 3; gi++) begin : g_blank
         assign blank[gi] = blank[gi+1] && (digit[gi] == 4'd0);
      end
   endgenerate
   assign blank[3] = (digit[3] == 4'd0);
   assign blank[0] = 1'b0;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    seg_decode = 7'b1000000;
         4'd1:    seg_decode = 7'b1111001;
         4'd2:    seg_decode = 7'b0100100;
         4'd3:    seg_decode = 7'b0110000;
         4'd4:    seg_decode = 7'b0011001;
         4'd5:    seg_decode = 7'b0010010;
         4'd6:    seg_decode = 7'b0000010;
         4'd7:    seg_decode = 7'b1111000;
         4'd8:    seg_decode = 7'b0000000;
         4'd9:    seg_decode = 7'b0010000;
         default: seg_decode = 7'b1111111;
      endcase
   endfunction

   assign wrap = (pre_reg == SCAN_DIV - 16'd1);

   always_comb begin
      pre_next = wrap ? 16'd0 : pre_reg + 16'd1;
      idx_next = wrap ? idx_reg + 2'd1 : idx_reg;
      an_next  = an_reg;
      seg_next = seg_reg;
      if (wrap) begin
         an_next  = ~(4'b0001 << idx_next);
         seg_next = blank[idx_next] ? 7'b1111111 : seg_decode(digit[idx_next]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_reg <= 16'd0;
         idx_reg <= 2'd0;
         an_reg  <= 4'b1110;
         seg_reg <= 7'b1000000;
      end else begin
         pre_reg <= pre_next;
         idx_reg <= idx_next;
         an_reg  <= an_next;
         seg_reg <= seg_next;
      end
   end

   assign bcd       = bcd_reg;
   assign bcd_valid = valid_reg;
   assign an        = an_reg;
   assign seg       = seg_reg;
   assign dp        = 1'b1;

endmodule

// File: tb/tb_count_display_driver.sv
// Randomized bench for count_display_driver against an arithmetic reference model
// of the conversion cadence and the digit scanner.
module tb_count_display_driver;

   localparam int SD = 4;

   logic        clk;
   logic        reset;
   logic [11:0] count;
   logic [15:0] bcd;
   logic        bcd_valid;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int n_checks = 0;
   int n_errs   = 0;
   bit chk_en   = 0;

   count_display_driver #(.SCAN_DIV(16'(SD))) dut (
      .clk(clk), .reset(reset), .count(count), .bcd(bcd),
      .bcd_valid(bcd_valid), .an(an), .seg(seg), .dp(dp)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   function automatic int pow10(input int i);
      case (i)
         0: return 1;
         1: return 10;
         2: return 100;
         default: return 1000;
      endcase
   endfunction

   function automatic logic [6:0] seg_of(input int num, input int i);
      int d;
      if (i > 0 && num < pow10(i)) return 7'b1111111;
      d = (num / pow10(i)) % 10;
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         default: return 7'b0010000;
      endcase
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [3:0] an_of(input int i);
      logic [3:0] a;
      a = 4'b1111;
      a[i] = 1'b0;
      return a;
   endfunction

   // Reference model: 14-cycle sample/publish cadence, value held as a plain integer.
   int         m_phase, m_num, m_sampled, m_pre, m_idx;
   logic       m_valid;
   logic [3:0] m_an;
   logic [6:0] m_seg;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_phase <= 0; m_num <= 0; m_sampled <= 0; m_pre <= 0; m_idx <= 0;
         m_valid <= 1'b0; m_an <= 4'b1110; m_seg <= 7'b1000000;
      end else begin
         if (m_pre == SD - 1) begin
            m_pre <= 0;
            m_idx <= (m_idx + 1) % 4;
            m_an  <= an_of((m_idx + 1) % 4);
            m_seg <= seg_of(m_num, (m_idx + 1) % 4);
         end else begin
            m_pre <= m_pre + 1;
         end
         m_valid <= (m_phase == 13);
         if (m_phase == 0)  m_sampled <= int'(count);
         if (m_phase == 13) m_num <= m_sampled;
         m_phase <= (m_phase == 13) ? 0 : m_phase + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check_val("bcd", bcd, to_bcd(m_num));
         check_val("bcd_valid", bcd_valid, m_valid);
         check_val("an", an, m_an);
         check_val("seg", seg, m_seg);
         check_val("dp", dp, 1'b1);
         check_val("nibble_le9", (bcd[3:0] > 9) || (bcd[7:4] > 9) || (bcd[11:8] > 9) || (bcd[15:12] > 9), 1'b0);
      end
   end

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!bcd_valid && n < 40);
   endtask

   task automatic check_digit(input string tag, input logic [3:0] an_want, input logic [6:0] seg_want);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (an !== an_want && k < 20);
      check_val({tag, "_an"}, an, an_want);
      check_val({tag, "_seg"}, seg, seg_want);
   endtask

   task automatic do_reset(input int cycles);
      @(posedge clk); #2;
      reset = 0;
      repeat (cycles) @(posedge clk);
      #1 reset = 1;
   endtask

   int lat;

   initial begin
      reset = 1;
      count = 12'd0;
      #1 reset = 0;
      chk_en = 1;
      repeat (3) @(negedge clk);
      check_val("rst_an", an, 4'b1110);
      check_val("rst_seg", seg, 7'b1000000);
      check_val("rst_dp", dp, 1'b1);
      check_val("rst_bcd", bcd, 16'h0000);
      check_val("rst_valid", bcd_valid, 1'b0);

      // count=15: first result latency and digit patterns
      @(posedge clk); #1;
      count = 12'd15;
      reset = 1;
      wait_valid(lat);
      check_val("first_latency", lat, 14);
      check_val("bcd_15", bcd, 16'h0015);
      wait_valid(lat);
      check_val("period_14", lat, 14);
      check_digit("d15_0", 4'b1110, 7'b0010010);
      check_digit("d15_1", 4'b1101, 7'b1111001);
      check_digit("d15_2", 4'b1011, 7'b1111111);
      check_digit("d15_3", 4'b0111, 7'b1111111);

      // count=4095: maximum, hundreds zero not blanked
      count = 12'd4095;
      repeat (30) @(posedge clk);
      #1 check_val("bcd_4095", bcd, 16'h4095);
      check_digit("dmax_0", 4'b1110, 7'b0010010);
      check_digit("dmax_1", 4'b1101, 7'b0010000);
      check_digit("dmax_2", 4'b1011, 7'b1000000);
      check_digit("dmax_3", 4'b0111, 7'b0011001);

      // abort mid-conversion while a nonzero result is showing
      lat = 0;
      do begin @(negedge clk); lat++; end while (!bcd_valid && lat < 40);
      check_val("abort_sync", bcd_valid, 1'b1);
      repeat (6) @(posedge clk);
      #2 reset = 0;
      #1 check_val("abort_bcd", bcd, 16'h0000);
      check_val("abort_seg", seg, 7'b1000000);
      check_val("abort_an", an, 4'b1110);
      @(posedge clk); #1 reset = 1;
      wait_valid(lat);
      check_val("abort_latency", lat, 14);
      check_val("abort_bcd_4095", bcd, 16'h4095);

      // count=0: only ones digit lit
      count = 12'd0;
      repeat (30) @(posedge clk);
      #1 check_val("bcd_0", bcd, 16'h0000);
      check_digit("dz_0", 4'b1110, 7'b1000000);
      check_digit("dz_1", 4'b1101, 7'b1111111);
      check_digit("dz_2", 4'b1011, 7'b1111111);
      check_digit("dz_3", 4'b0111, 7'b1111111);

      // free-running counter after reset
      do_reset(2);
      count = 12'd0;
      repeat (200) begin
         @(posedge clk); #1;
         count = count + 12'd1;
      end

      // random values, random hold lengths, occasional async reset
      repeat (60) begin
         count = 12'($urandom_range(0, 4095));
         repeat ($urandom_range(1, 20)) @(posedge clk);
         #1;
         if ($urandom_range(0, 9) == 0)
            do_reset($urandom_range(1, 3));
      end
      repeat (30) @(posedge clk);

      @(negedge clk);
      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
